// File: rtl/mul_seq_ctrl.sv
// Address sequencer and dot-product accumulator for a BRAM-fed multiplier.
// Walks BRAM A and B from independent bases, aligns a valid strobe with the product and sums it.
module mul_seq_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PIPE_LAT = 1,
    parameter int unsigned ACC_W    = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] mul_product,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              prod_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    // Top stage of the delay line is the prod_valid output itself.
    localparam logic [PIPE_LAT-1:0] DlTop = PIPE_LAT'(1) << (PIPE_LAT - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [PIPE_LAT-1:0] dl_q, dl_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                dl_pending;

    // Products still in flight behind the one currently on mul_product.
    assign dl_pending = |(dl_q & ~DlTop);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        dl_d     = dl_q << 1;
        acc_d    = acc_q;

        if (dl_q[PIPE_LAT-1]) begin
            acc_d = acc_q + ACC_W'(mul_product);
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    len_d    = length;
                    acc_d    = '0;
                    addr_a_d = base_a;
                    addr_b_d = base_b;
                    issued_d = (ADDR_W + 1)'(1);
                    state_d  = (length == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                dl_d = (dl_q << 1) | PIPE_LAT'(1);
                if (issued_q < len_q) begin
                    addr_a_d = addr_a_q + ADDR_W'(1);
                    addr_b_d = addr_b_q + ADDR_W'(1);
                    issued_d = issued_q + (ADDR_W + 1)'(1);
                end else begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The last product is accumulated on the same edge that leaves DRAIN.
                if (!dl_pending) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Cancel freezes the partial sum and addresses, and discards in-flight products.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            dl_d     = '0;
            acc_d    = acc_q;
            addr_a_d = addr_a_q;
            addr_b_d = addr_b_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            issued_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            dl_q     <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            dl_q     <= dl_d;
            acc_q    <= acc_d;
        end
    end

    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign prod_valid = dl_q[PIPE_LAT-1];
    assign acc_out    = acc_q;
    assign busy       = (state_q == StIssue) || (state_q == StDrain);
    assign done       = (state_q == StDone);

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the BRAM-fed multiplier datapath: two single-port BRAMs (A and B) drive one multiplier. On `start` it walks both BRAMs from independent base addresses for a programmed number of elements and aligns a valid strobe with the multiplier output using a parameterised latency delay line. It accumulates the products into a dot-product result and reports completion with a one-cycle `done` pulse. It replaces the free-running address counters and the fixed enable-delay generators around the multiplier.

## Interface
- `ADDR_W`, 4: BRAM address width; the maximum vector length is 2^ADDR_W.
- `DATA_W`, 32: multiplier product width.
- `PIPE_LAT`, 1: clock edges from an address being presented to its product being valid on `mul_product`. Use 1 for the unpipelined multiplier; a pipelined build adds its multiplier stages. Must be ≥1.
- `ACC_W`, DATA_W+ADDR_W: accumulator width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: synchronous cancel of a run in progress.
- `base_a` in ADDR_W: first BRAM A address; latched at start.
- `base_b` in ADDR_W: first BRAM B address; latched at start.
- `length` in ADDR_W+1: element count, 0..2^ADDR_W; latched at start.
- `mul_product` in DATA_W: multiplier output, unsigned.
- `addr_a` out ADDR_W: registered BRAM A address.
- `addr_b` out ADDR_W: registered BRAM B address.
- `prod_valid` out 1: registered; high in each cycle `mul_product` holds a product belonging to the current run.
- `acc_out` out ACC_W: registered running or final sum.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE. The reset state is IDLE.
- Reset values: `addr_a`=0, `addr_b`=0, `prod_valid`=0, `acc_out`=0, `busy`=0, `done`=0; delay line and element counter cleared.
- IDLE, `start`=1, `abort`=0: latch `length`; set `acc_out`←0 and `addr_a`←`base_a`, `addr_b`←`base_b`.
  - If `length`=0, go to DONE.
  - Otherwise go to ISSUE and set `issued`=1.
- IDLE, `start`=1 and `abort`=1: abort wins; start is ignored and the FSM stays in IDLE.
- ISSUE: the address pair currently presented is pushed into the valid delay line.
  - If `issued`<`length`: increment both addresses and `issued`.
  - Else go to DRAIN. Addresses hold their last value.
- Address arithmetic is modulo 2^ADDR_W, so base 14 with length 4 visits 14, 15, 0, 1.
- Delay line: a PIPE_LAT-deep shift register of issue flags; its output is `prod_valid`.
- Accumulation: when `prod_valid`=1, `acc_out`←`acc_out`+zero-extended `mul_product`. The default ACC_W cannot overflow at maximum length.
- DRAIN: stay until the delay line is empty and the last product has been accumulated, then go to DONE.
- DONE: assert `done`=1 for one cycle, then go to IDLE. `start` is ignored in DONE.
- `acc_out` holds its final value until the next accepted start.
- `abort` in ISSUE, DRAIN or DONE: on the next edge go to IDLE.
  - The delay line is cleared, so `prod_valid`=0 from the next cycle.
  - No `done` pulse is produced. `acc_out` freezes at its partial sum; addresses hold.
- `start` outside IDLE is dropped and not queued.
- Asserting `reset` mid-run clears everything immediately. The first cycle after release is IDLE.

## Timing
- `start` is sampled at edge k. Address pair i (0-based) is presented during cycle k+1+i.
- The product for pair i is valid, with `prod_valid`=1, during cycle k+1+i+PIPE_LAT.
- Last product: cycle k+length+PIPE_LAT; it is accumulated at the end of that cycle.
- `done`=1 during cycle k+length+PIPE_LAT+1, with the final `acc_out`. Total latency is length+PIPE_LAT+1 cycles.
- `busy`=1 from cycle k+1 through cycle k+length+PIPE_LAT; it is 0 in the `done` cycle.
- For `length`=0: `done`=1 in cycle k+1, `acc_out`=0, `busy` never rises, no addresses are issued.
- Back-to-back runs: the earliest next start is sampled at the edge ending the first IDLE cycle after `done`.

## Test plan
- Basic sum, PIPE_LAT=1: BRAM A[i]=i+1, B[i]=2; base 0/0, length 4. Required:
  - addresses 0..3 in cycles k+1..k+4;
  - `prod_valid` high in cycles k+2..k+5;
  - `done` in cycle k+6 with `acc_out`=20.
- Wrap and offset: base_a=14, base_b=3, length=4. Required: `addr_a` sequence 14, 15, 0, 1; `addr_b` sequence 3, 4, 5, 6; `acc_out` equals the matching dot product.
- Zero and max length:
  - length 0 → `done` at k+1, `acc_out`=0, `busy` stays 0;
  - length 16, all words 0xFFFFFFFF → `acc_out`=16×0xFFFFFFFF with no overflow.
- Pipelined latency, PIPE_LAT=5, length 3: `prod_valid` high in cycles k+6..k+8, `done` at k+9.
- Abort and start collisions:
  - `abort` in the cycle after `addr_a`=2 → `prod_valid` low next cycle, IDLE, no `done`, `acc_out` holds its partial value;
  - `start` held during the run or during the `done` cycle → no restart.
- Async reset: assert `reset`=0 mid-DRAIN between clock edges → all outputs are 0 immediately. After release, a fresh run with the first-scenario setup yields 20.
